fetch_stage: RTL and testbench

Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It sits directly upstream of the decode stage. It consumes the stall, flush and redirect controls produced by the hazard detection unit and delivers the fetched instruction word plus PC+1 into IF/ID.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage_if_id_register.sv | 42 ++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the fetch FSM states.
package cpu_pkg;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 19;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 19
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: load-enable, flush-clear (higher priority) and async reset.
module if_id_register #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [PC_W-1:0]    next_pc1,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc1,
  output logic               valid
);
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pc1_reg;
  logic               valid_reg;

  // A cleared entry is a NOP bubble with a zero PC+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg <= INSTR_W'(NOP_INSTR);
      pc1_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      instr_reg <= INSTR_W'(NOP_INSTR);
      pc1_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg <= next_instr;
      pc1_reg   <= next_pc1;
      valid_reg <= 1'b1;
    end
  end

  assign instr = instr_reg;
  assign pc1   = pc1_reg;
  assign valid = valid_reg;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request FSM (FETCH/HOLD/DROP) and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / bubble_cnt outputs.
module fetch_stage #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IF_ID_Wr,
  input  logic               flush,
  input  logic               PCWr,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    jump_target,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [PC_W-1:0]    IF_ID_pc1,
  output logic               IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        bubble_cnt
`endif
);
  import cpu_pkg::*;

  fetch_state_t       state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [PC_W-1:0]    drop_addr_reg, drop_addr_next;
  logic [INSTR_W-1:0] buf_reg, buf_next;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    target;
  logic               accept;
  logic               clear;
  logic [INSTR_W-1:0] accept_instr;

  assign pc_inc = pc_reg + PC_W'(1);
  assign target = PCWr ? branch_target : jump_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= '0;
      buf_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
      buf_reg       <= buf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    buf_next       = buf_reg;
    accept         = 1'b0;
    accept_instr   = imem.rdata;
    unique case (state_reg)
      FETCH: begin
        if (flush) begin
          pc_next = target;
          // A request that has not been answered cannot be withdrawn: remember it.
          if (!imem.ack) begin
            drop_addr_next = pc_reg;
            state_next     = DROP;
          end
        end else if (imem.ack) begin
          if (IF_ID_Wr) begin
            accept  = 1'b1;
            pc_next = pc_inc;
          end else begin
            buf_next   = imem.rdata;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (IF_ID_Wr) begin
          accept       = 1'b1;
          accept_instr = buf_reg;
          pc_next      = pc_inc;
          state_next   = FETCH;
        end
      end
      DROP: begin
        if (flush) begin
          pc_next = target;
        end
        if (imem.ack) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Any IF/ID write that is not an accepted word is a bubble; flush overrides a stall.
  assign clear = flush | (IF_ID_Wr & ~accept);

  // Request lines depend only on state/registers, never on imem.ack.
  assign imem.req  = ~rst & (state_reg != HOLD);
  assign imem.addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;

  if_id_register #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .clear      (clear),
    .next_instr (accept_instr),
    .next_pc1   (pc_inc),
    .instr      (IF_ID_instr),
    .pc1        (IF_ID_pc1),
    .valid      (IF_ID_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] bubble_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (!IF_ID_Wr && !flush && stall_cnt_reg != 16'hFFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (clear && bubble_cnt_reg != 16'hFFFF) begin
        bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed per-cycle vector table, then random traffic against a flag-level model.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int PW = 12;
  localparam int IW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          IF_ID_Wr = 1'b0;
  logic          flush = 1'b0;
  logic          PCWr = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic [PW-1:0] jump_target = '0;
  logic [IW-1:0] IF_ID_instr;
  logic [PW-1:0] IF_ID_pc1;
  logic          IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;

  fetch_stage_if #(.PC_W(PW), .INSTR_W(IW)) imem ();

  fetch_stage #(.PC_W(PW), .INSTR_W(IW), .RESET_PC(12'h000)) dut (
    .clk           (clk),
    .rst           (rst),
    .IF_ID_Wr      (IF_ID_Wr),
    .flush         (flush),
    .PCWr          (PCWr),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem          (imem.master),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_pc1     (IF_ID_pc1),
    .IF_ID_valid   (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: every word is distinct and non-zero, derived from its address.
  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {7'h53, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle's inputs just after the edge; memory answers only a live request.
  task automatic drive(input logic r, input logic w, input logic f, input logic p,
                       input logic [PW-1:0] bt, input logic [PW-1:0] jt, input logic a);
    rst = r;
    IF_ID_Wr = w;
    flush = f;
    PCWr = p;
    branch_target = bt;
    jump_target = jt;
    #1;
    imem.ack = a & imem.req;
    imem.rdata = imem.ack ? mem_word(imem.addr) : IW'($urandom);
    #1;
  endtask

  typedef struct packed {
    logic          r, w, f, p;
    logic [PW-1:0] t;
    logic          a;
    logic          e_req;
    logic [PW-1:0] e_addr;
    logic          e_valid;
    logic [PW-1:0] e_pc1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic w, input logic f, input logic p,
                              input logic [PW-1:0] t, input logic a, input logic e_req,
                              input logic [PW-1:0] e_addr, input logic e_valid,
                              input logic [PW-1:0] e_pc1);
    vec_t v;
    v = '{r: r, w: w, f: f, p: p, t: t, a: a, e_req: e_req, e_addr: e_addr,
          e_valid: e_valid, e_pc1: e_pc1};
    vecs.push_back(v);
  endfunction

  // Behavioural model: PC, a held word, and an outstanding stale request to be discarded.
  logic [PW-1:0] m_pc;
  logic          m_held;
  logic [IW-1:0] m_buf;
  logic          m_stale;
  logic [PW-1:0] m_stale_addr;
  logic [IW-1:0] m_instr;
  logic [PW-1:0] m_pc1;
  logic          m_valid;
  int            m_stall_cnt;
  int            m_bubble_cnt;

  function automatic void model_reset();
    m_pc = 12'h000;
    m_held = 1'b0;
    m_buf = '0;
    m_stale = 1'b0;
    m_stale_addr = '0;
    m_instr = '0;
    m_pc1 = '0;
    m_valid = 1'b0;
    m_stall_cnt = 0;
    m_bubble_cnt = 0;
  endfunction

  function automatic void model_step(input logic w, input logic f, input logic [PW-1:0] tgt,
                                     input logic ack, input logic [IW-1:0] rdata);
    logic bubble;
    bubble = 1'b0;
    if (f) begin
      bubble = 1'b1;
      if (m_stale) begin
        if (ack) m_stale = 1'b0;
      end else if (!m_held && !ack) begin
        m_stale = 1'b1;
        m_stale_addr = m_pc;
      end
      m_held = 1'b0;
      m_pc = tgt;
    end else if (m_held) begin
      if (w) begin
        m_instr = m_buf;
        m_pc1 = m_pc + 12'd1;
        m_valid = 1'b1;
        m_pc = m_pc + 12'd1;
        m_held = 1'b0;
      end
    end else if (m_stale) begin
      if (w) bubble = 1'b1;
      if (ack) m_stale = 1'b0;
    end else if (ack) begin
      if (w) begin
        m_instr = rdata;
        m_pc1 = m_pc + 12'd1;
        m_valid = 1'b1;
        m_pc = m_pc + 12'd1;
      end else begin
        m_held = 1'b1;
        m_buf = rdata;
      end
    end else if (w) begin
      bubble = 1'b1;
    end
    if (bubble) begin
      m_instr = '0;
      m_pc1 = '0;
      m_valid = 1'b0;
    end
    if (!w && !f && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
    if (bubble && m_bubble_cnt < 16'hFFFF) m_bubble_cnt++;
  endfunction

  initial begin
    logic [IW-1:0] e_instr;
    logic          r, w, f, p, a, e_req;
    logic [PW-1:0] bt, jt, e_addr;

    imem.ack = 1'b0;
    imem.rdata = '0;

    // Reset and zero-wait streaming
    add(1,1,0,0,12'h000,0, 0,12'h000,0,12'h000);
    add(1,1,0,0,12'h000,0, 0,12'h000,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h000,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h001,1,12'h001);
    add(0,1,0,0,12'h000,1, 1,12'h002,1,12'h002);
    // Three stall cycles, word 3 buffered, then released
    add(0,0,0,0,12'h000,1, 1,12'h003,1,12'h003);
    add(0,0,0,0,12'h000,0, 0,12'h000,1,12'h003);
    add(0,0,0,0,12'h000,0, 0,12'h000,1,12'h003);
    add(0,1,0,0,12'h000,0, 0,12'h000,1,12'h003);
    add(0,1,0,0,12'h000,1, 1,12'h004,1,12'h004);
    // Taken branch to 0x040 with zero-wait memory
    add(0,1,1,1,12'h040,1, 1,12'h005,1,12'h005);
    add(0,1,0,0,12'h000,1, 1,12'h040,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h041,1,12'h041);
    add(0,1,0,0,12'h000,1, 1,12'h042,1,12'h042);
    // Flush together with stall: flush wins; jump to 0xFFF then wrap to 0
    add(0,0,1,0,12'hFFF,1, 1,12'h043,1,12'h043);
    add(0,1,0,0,12'h000,1, 1,12'hFFF,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h000,1,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h001,1,12'h001);
    add(0,1,0,0,12'h000,1, 1,12'h002,1,12'h002);
    add(0,1,0,0,12'h000,1, 1,12'h003,1,12'h003);
    add(0,1,0,0,12'h000,1, 1,12'h004,1,12'h004);
    // Jump to 0x100 while the request to 0x005 waits four cycles
    add(0,1,1,0,12'h100,0, 1,12'h005,1,12'h005);
    add(0,1,0,0,12'h000,0, 1,12'h005,0,12'h000);
    add(0,1,0,0,12'h000,0, 1,12'h005,0,12'h000);
    add(0,1,0,0,12'h000,0, 1,12'h005,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h005,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h100,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h101,1,12'h101);
    // Flush while holding a buffered word
    add(0,0,0,0,12'h000,1, 1,12'h102,1,12'h102);
    add(0,0,1,1,12'h200,0, 0,12'h000,1,12'h102);
    add(0,1,0,0,12'h000,1, 1,12'h200,0,12'h000);
    // Reset mid-wait with simultaneous flush and stall
    add(0,0,0,0,12'h000,0, 1,12'h201,1,12'h201);
    add(1,0,1,1,12'h300,0, 0,12'h000,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h000,0,12'h000);
    add(0,1,0,0,12'h000,1, 1,12'h001,1,12'h001);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].w, vecs[i].f, vecs[i].p, vecs[i].t, vecs[i].t, vecs[i].a);
      e_instr = vecs[i].e_valid ? mem_word(vecs[i].e_pc1 - 12'd1) : '0;
      chk($sformatf("vec%0d req", i), 32'(imem.req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), 32'(imem.addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d valid", i), 32'(IF_ID_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d pc1", i), 32'(IF_ID_pc1), 32'(vecs[i].e_pc1));
      chk($sformatf("vec%0d instr", i), 32'(IF_ID_instr), 32'(e_instr));
      $display("vec %0d rst=%b wr=%b flush=%b ack=%b req=%b addr=%h valid=%b pc1=%h",
               i, rst, IF_ID_Wr, flush, imem.ack, imem.req, imem.addr, IF_ID_valid, IF_ID_pc1);
      @(posedge clk);
      #1;
    end

    // Random traffic against the model; the first cycle is a reset
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r  = (c == 0) || ($urandom_range(0, 199) == 0);
      w  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 7) == 0);
      p  = 1'($urandom);
      bt = PW'($urandom);
      jt = PW'($urandom);
      a  = ($urandom_range(0, 2) != 0);
      drive(r, w, f, p, bt, jt, a);
      if (r) model_reset();
      e_req  = !r && !m_held;
      e_addr = m_stale ? m_stale_addr : m_pc;
      chk($sformatf("rnd%0d req", c), 32'(imem.req), 32'(e_req));
      if (e_req) chk($sformatf("rnd%0d addr", c), 32'(imem.addr), 32'(e_addr));
      chk($sformatf("rnd%0d valid", c), 32'(IF_ID_valid), 32'(m_valid));
      chk($sformatf("rnd%0d pc1", c), 32'(IF_ID_pc1), 32'(m_pc1));
      chk($sformatf("rnd%0d instr", c), 32'(IF_ID_instr), 32'(m_instr));
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("rnd%0d stall_cnt", c), 32'(stall_cnt), 32'(m_stall_cnt));
      chk($sformatf("rnd%0d bubble_cnt", c), 32'(bubble_cnt), 32'(m_bubble_cnt));
`endif
      if (!r) model_step(w, f, p ? bt : jt, imem.ack, imem.rdata);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
